vx_tma_mem_responder: RTL and testbench
=======================================

Name: vx_tma_mem_responder

Overview:
- Memory-side responder for the per-block local-memory request/response channel that TMA slices drive as initiators.
- Accepts multi-lane read/write requests and services them from an internal word-addressed SRAM model.
- Returns in-order tagged read responses, plus optional write acks, through a credit-limited response FIFO.
- Used as the local-memory endpoint of a TMA block and as the slave-side model in TMA unit benches.

Parameters:
- NUM_LANES, 4, lanes per request
- WORD_SIZE, 4, bytes per lane word
- ADDR_WIDTH, 10, word-address width per lane; memory holds 2^ADDR_WIDTH words
- TAG_WIDTH, 8, request tag width, returned unchanged
- RSP_DEPTH, 4, response FIFO entries (power of two, >=2)
- WRITE_ACK, 0, 1 = writes also return a response

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- req_valid  input  1  request valid
- req_rw  input  1  1 = write, 0 = read
- req_mask  input  NUM_LANES  active lanes
- req_byteen  input  NUM_LANES*WORD_SIZE  per-lane byte enables (writes only)
- req_addr  input  NUM_LANES*ADDR_WIDTH  per-lane word address
- req_data  input  NUM_LANES*WORD_SIZE*8  per-lane write data
- req_tag  input  TAG_WIDTH  request tag
- req_ready  output  1  request accepted when valid&ready
- rsp_valid  output  1  response valid
- rsp_mask  output  NUM_LANES  copy of the request mask
- rsp_data  output  NUM_LANES*WORD_SIZE*8  read data (zero for inactive lanes and for write acks)
- rsp_tag  output  TAG_WIDTH  copy of the request tag
- rsp_ready  input  1  response consumed when valid&ready

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, FIFO empty, occupancy counter occ=0, so req_ready=1 on the first cycle after release. rsp_mask/rsp_data/rsp_tag=0. Memory contents are not reset.
- Accept condition: req_valid&req_ready on a rising edge.
- req_ready = (occ < RSP_DEPTH).
  - Combinational from registered state only; independent of req_valid and req_rw.
- occ counts accepted response-producing requests not yet consumed.
  - Increment on accept of a read, or of a write when WRITE_ACK=1.
  - Decrement on rsp_valid&rsp_ready.
  - Both in the same cycle: occ unchanged.
- Write, at the accept edge: for each lane with its mask bit set, write each byte whose byteen bit is set.
  - Lanes are applied in ascending index order; on an address collision the highest lane's enabled bytes win per byte.
  - Write with mask=0: no memory change; still acked if WRITE_ACK=1.
- Read: memory is sampled at the accept edge into a one-entry stage register S1 (data, mask, tag).
  - Inactive lanes are forced to zero.
  - Read-after-write across consecutive accepted requests returns the new data.
- S1 pushes into the FIFO on the following cycle. With the FIFO empty and rsp_ready=1, rsp_valid rises the cycle after accept (latency 1).
  - S1 never stalls: occ guarantees FIFO space.
- Output order equals accept order, for reads and acks alike.
- rsp_valid/mask/data/tag hold stable while rsp_valid&!rsp_ready.
- Write with WRITE_ACK=0: consumes no occ; no response.
- Full: occ==RSP_DEPTH, so req_ready=0. A pop in that cycle raises req_ready in the next cycle, not combinationally.
- Reset mid-operation: all in-flight and queued responses are dropped immediately (rsp_valid=0). Memory retains written data.
- Addresses wrap naturally at 2^ADDR_WIDTH (no out-of-range case).

Test Plan:
- Write lane0..3 addr 0x10..0x13, data 0xA0+i, byteen all-1, WRITE_ACK=0; then read the same addresses with mask 0xF, tag 0x5A -> exactly one response, one cycle after accept: data A0..A3, tag 0x5A, mask 0xF; no response for the write.
- Hold rsp_ready=0 and issue 6 back-to-back reads with RSP_DEPTH=4 -> req_ready drops after the 4th accept; release rsp_ready -> tags return in order; req_ready returns the cycle after the first pop.
- Write 0xFFFFFFFF to addr 3, then a write with byteen=0b0010 and data 0x00001200; read addr 3 with mask 0b0101 -> lane0 0xFFFF12FF, lanes 1 and 3 return 0.
- Write with lanes 1 and 2 both at addr 7, data 0x11/0x22 -> a read returns 0x22. With WRITE_ACK=1 the write yields a response with data 0 and the write's tag.
- At occ==RSP_DEPTH, pulse rsp_ready with req_valid held high -> occ stays 4, one accept per pop, no FIFO overflow, no duplicated tags.
- Assert reset with 3 responses queued -> rsp_valid=0 asynchronously; after release req_ready=1, and a read of previously written data returns the preserved values.

Source files
------------

// File: rtl/vx_tma_mem_responder_if.sv
// Request/response channel between a TMA initiator (master) and a local-memory
// responder (slave).
interface vx_tma_mem_responder_if #(
  parameter int NUM_LANES  = 4,
  parameter int WORD_SIZE  = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 8
);
  // Handshakes: a beat transfers on a rising edge where valid & ready are both
  // high. The source holds all payload fields stable while valid & !ready;
  // ready may depend on registered state only, never on the same-cycle valid.
  logic                              req_valid;
  logic                              req_rw;
  logic [NUM_LANES-1:0]              req_mask;
  logic [NUM_LANES*WORD_SIZE-1:0]    req_byteen;
  logic [NUM_LANES*ADDR_WIDTH-1:0]   req_addr;
  logic [NUM_LANES*WORD_SIZE*8-1:0]  req_data;
  logic [TAG_WIDTH-1:0]              req_tag;
  logic                              req_ready;

  logic                              rsp_valid;
  logic [NUM_LANES-1:0]              rsp_mask;
  logic [NUM_LANES*WORD_SIZE*8-1:0]  rsp_data;
  logic [TAG_WIDTH-1:0]              rsp_tag;
  logic                              rsp_ready;

  modport master (
    output req_valid, req_rw, req_mask, req_byteen, req_addr, req_data, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_mask, rsp_data, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_rw, req_mask, req_byteen, req_addr, req_data, req_tag,
    output req_ready,
    output rsp_valid, rsp_mask, rsp_data, rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/vx_tma_mem_responder.sv
// Local-memory responder: multi-lane word SRAM model with a one-entry read stage
// feeding an in-order, credit-limited response FIFO.
module vx_tma_mem_responder #(
  parameter int NUM_LANES  = 4,
  parameter int WORD_SIZE  = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 8,
  parameter int RSP_DEPTH  = 4,
  parameter int WRITE_ACK  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_tma_mem_responder_if.slave  bus
);
  localparam int WW        = WORD_SIZE * 8;
  localparam int DW        = NUM_LANES * WW;
  localparam int MEM_WORDS = 1 << ADDR_WIDTH;
  localparam int PTR_W     = $clog2(RSP_DEPTH);
  localparam int OCC_W     = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(RSP_DEPTH);
  localparam logic             ACK_WR  = (WRITE_ACK != 0);

  logic [WW-1:0] mem [MEM_WORDS];

  logic accept;
  logic wr_en;
  logic produce;
  logic pop;
  logic rsp_valid;

  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [NUM_LANES-1:0] s1_mask_q, s1_mask_d;
  logic [DW-1:0]        s1_data_q, s1_data_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;

  logic [NUM_LANES-1:0] fifo_mask [RSP_DEPTH];
  logic [DW-1:0]        fifo_data [RSP_DEPTH];
  logic [TAG_WIDTH-1:0] fifo_tag  [RSP_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     cnt_q, cnt_d;

  // occ covers both S1 and the FIFO, so a granted request always finds a slot.
  assign bus.req_ready = (occ_q < DEPTH_C);
  assign accept        = bus.req_valid & bus.req_ready;
  assign wr_en         = accept & bus.req_rw;
  assign produce       = accept & (~bus.req_rw | ACK_WR);
  assign rsp_valid     = (cnt_q != '0);
  assign pop           = rsp_valid & bus.rsp_ready;

  // Later lanes overwrite earlier ones, so the highest colliding lane wins per byte.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (bus.req_mask[l]) begin
          for (int b = 0; b < WORD_SIZE; b++) begin
            if (bus.req_byteen[l*WORD_SIZE + b]) begin
              mem[bus.req_addr[l*ADDR_WIDTH +: ADDR_WIDTH]][b*8 +: 8] <= bus.req_data[l*WW + b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    s1_valid_d = produce;
    s1_mask_d  = s1_mask_q;
    s1_tag_d   = s1_tag_q;
    s1_data_d  = s1_data_q;
    if (produce) begin
      s1_mask_d = bus.req_mask;
      s1_tag_d  = bus.req_tag;
      s1_data_d = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (!bus.req_rw && bus.req_mask[l]) begin
          s1_data_d[l*WW +: WW] = mem[bus.req_addr[l*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    occ_d    = occ_q;
    if (s1_valid_q) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)        rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({s1_valid_q, pop})
      2'b10:   cnt_d = cnt_q + OCC_W'(1);
      2'b01:   cnt_d = cnt_q - OCC_W'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({produce, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_mask_q  <= '0;
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      s1_valid_q <= s1_valid_d;
      s1_mask_q  <= s1_mask_d;
      s1_data_q  <= s1_data_d;
      s1_tag_q   <= s1_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      fifo_mask[wr_ptr_q] <= s1_mask_q;
      fifo_data[wr_ptr_q] <= s1_data_q;
      fifo_tag[wr_ptr_q]  <= s1_tag_q;
    end
  end

  // Payload is gated by valid so an empty or freshly reset FIFO presents zeros.
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_mask  = rsp_valid ? fifo_mask[rd_ptr_q] : '0;
  assign bus.rsp_data  = rsp_valid ? fifo_data[rd_ptr_q] : '0;
  assign bus.rsp_tag   = rsp_valid ? fifo_tag[rd_ptr_q]  : '0;
endmodule

// File: tb/tb_vx_tma_mem_responder.sv
// Directed bench for vx_tma_mem_responder: one instance without write acks, one with.
module tb_vx_tma_mem_responder;
  localparam int NL = 4;
  localparam int TW = 8;
  localparam int DW = 128;
  localparam int RW = TW + NL + DW;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  logic [RW-1:0] exp_q[$];

  localparam logic [39:0]  ADDR_LIN = {10'h13, 10'h12, 10'h11, 10'h10};
  localparam logic [127:0] DATA_LIN = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

  vx_tma_mem_responder_if #(.NUM_LANES(4), .WORD_SIZE(4), .ADDR_WIDTH(10), .TAG_WIDTH(8)) bus0 ();
  vx_tma_mem_responder_if #(.NUM_LANES(4), .WORD_SIZE(4), .ADDR_WIDTH(10), .TAG_WIDTH(8)) bus1 ();

  vx_tma_mem_responder #(.NUM_LANES(4), .WORD_SIZE(4), .ADDR_WIDTH(10), .TAG_WIDTH(8),
                         .RSP_DEPTH(4), .WRITE_ACK(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  vx_tma_mem_responder #(.NUM_LANES(4), .WORD_SIZE(4), .ADDR_WIDTH(10), .TAG_WIDTH(8),
                         .RSP_DEPTH(4), .WRITE_ACK(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  function automatic logic [RW-1:0] pk(input logic [7:0] tag, input logic [3:0] mask,
                                       input logic [127:0] data);
    return {tag, mask, data};
  endfunction

  function automatic logic [127:0] rd_exp(input int lane);
    logic [127:0] d;
    d = '0;
    d[lane*32 +: 32] = 32'(32'hA0 + lane);
    return d;
  endfunction

  // driver tasks
  task automatic send0(input logic rw, input logic [3:0] mask, input logic [15:0] be,
                       input logic [39:0] addr, input logic [127:0] data, input logic [7:0] tag,
                       input logic [127:0] exp_d, input logic push);
    int budget;
    @(negedge clk);
    bus0.req_rw = rw; bus0.req_mask = mask; bus0.req_byteen = be;
    bus0.req_addr = addr; bus0.req_data = data; bus0.req_tag = tag;
    bus0.req_valid = 1'b1;
    budget = 0;
    while (!bus0.req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!bus0.req_ready) check("send0_ready", bus0.req_ready, 1'b1);
    else if (push) exp_q.push_back(pk(tag, mask, exp_d));
    @(negedge clk);
    bus0.req_valid = 1'b0;
  endtask

  task automatic send1(input logic rw, input logic [3:0] mask, input logic [15:0] be,
                       input logic [39:0] addr, input logic [127:0] data, input logic [7:0] tag);
    int budget;
    @(negedge clk);
    bus1.req_rw = rw; bus1.req_mask = mask; bus1.req_byteen = be;
    bus1.req_addr = addr; bus1.req_data = data; bus1.req_tag = tag;
    bus1.req_valid = 1'b1;
    budget = 0;
    while (!bus1.req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!bus1.req_ready) check("send1_ready", bus1.req_ready, 1'b1);
    @(negedge clk);
    bus1.req_valid = 1'b0;
  endtask

  task automatic drive_rd(input logic [7:0] tag, input int lane);
    bus0.req_rw = 1'b0; bus0.req_mask = 4'(1 << lane); bus0.req_byteen = '0;
    bus0.req_addr = ADDR_LIN; bus0.req_data = '0; bus0.req_tag = tag;
    bus0.req_valid = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // scoreboard: samples mid-low-phase, after the negedge drivers have settled
  initial begin
    logic [RW-1:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (reset && bus0.rsp_valid && bus0.rsp_ready) begin
        got = {bus0.rsp_tag, bus0.rsp_mask, bus0.rsp_data};
        check("rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("rsp_order", got, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_rw = 1'b0; bus0.req_mask = '0; bus0.req_byteen = '0;
    bus0.req_addr = '0; bus0.req_data = '0; bus0.req_tag = '0; bus0.rsp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_rw = 1'b0; bus1.req_mask = '0; bus1.req_byteen = '0;
    bus1.req_addr = '0; bus1.req_data = '0; bus1.req_tag = '0; bus1.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    check("rst_req_ready", bus0.req_ready, 1'b1);
    check("rst_rsp_valid", bus0.rsp_valid, 1'b0);
    check("rst_rsp_tag",   bus0.rsp_tag,   8'h00);
    check("rst_rsp_mask",  bus0.rsp_mask,  4'h0);
    check("rst_rsp_data",  bus0.rsp_data,  128'h0);

    // write then read, latency and single response
    send0(1'b1, 4'hF, 16'hFFFF, ADDR_LIN, DATA_LIN, 8'h01, '0, 1'b0);
    check("t1_no_wr_rsp", bus0.rsp_valid, 1'b0);
    @(negedge clk);
    check("t1_no_wr_rsp2", bus0.rsp_valid, 1'b0);
    send0(1'b0, 4'hF, 16'h0, ADDR_LIN, '0, 8'h5A, DATA_LIN, 1'b1);
    check("t1_lat_s1", bus0.rsp_valid, 1'b0);
    @(negedge clk);
    check("t1_rsp_valid", bus0.rsp_valid, 1'b1);
    check("t1_rsp_tag",   bus0.rsp_tag,   8'h5A);
    check("t1_rsp_mask",  bus0.rsp_mask,  4'hF);
    check("t1_rsp_data",  bus0.rsp_data,  DATA_LIN);
    @(negedge clk);
    check("t1_single", bus0.rsp_valid, 1'b0);
    drain("t1_drain");

    // back-to-back reads into a stalled output
    bus0.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_ready_open", bus0.req_ready, 1'b1);
      drive_rd(8'(8'h20 + i), i);
      exp_q.push_back(pk(8'(8'h20 + i), 4'(1 << i), rd_exp(i)));
    end
    @(negedge clk);
    check("t2_ready_full", bus0.req_ready, 1'b0);
    drive_rd(8'h24, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t2_hold_ready", bus0.req_ready, 1'b0);
      check("t2_hold_valid", bus0.rsp_valid, 1'b1);
      check("t2_hold_tag",   bus0.rsp_tag,   8'h20);
    end
    @(negedge clk);
    check("t2_ready_pre_pop", bus0.req_ready, 1'b0);
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    check("t2_ready_after_pop", bus0.req_ready, 1'b1);
    check("t2_next_tag", bus0.rsp_tag, 8'h21);
    exp_q.push_back(pk(8'h24, 4'h1, rd_exp(0)));
    @(negedge clk);
    check("t2_ready_steady", bus0.req_ready, 1'b1);
    drive_rd(8'h25, 1);
    exp_q.push_back(pk(8'h25, 4'h2, rd_exp(1)));
    @(negedge clk);
    bus0.req_valid = 1'b0;
    drain("t2_drain");

    // partial byte enables and masked-off lanes
    send0(1'b1, 4'h1, 16'h000F, {4{10'h003}}, {4{32'hFFFF_FFFF}}, 8'h02, '0, 1'b0);
    send0(1'b1, 4'h1, 16'h0002, {4{10'h003}}, {4{32'h0000_1200}}, 8'h03, '0, 1'b0);
    send0(1'b0, 4'h5, 16'h0, {4{10'h003}}, '0, 8'h33,
          {32'h0, 32'hFFFF_12FF, 32'h0, 32'hFFFF_12FF}, 1'b1);
    drain("t3_drain");

    // lane collision: highest lane wins
    send0(1'b1, 4'h6, 16'hFFFF, {10'h0, 10'h007, 10'h007, 10'h0},
          {32'h0, 32'h22, 32'h11, 32'h0}, 8'h04, '0, 1'b0);
    send0(1'b0, 4'h1, 16'h0, {4{10'h007}}, '0, 8'h44, {96'h0, 32'h22}, 1'b1);
    drain("t4_drain");

    // write acks on the WRITE_ACK instance
    send1(1'b1, 4'h6, 16'hFFFF, {10'h0, 10'h007, 10'h007, 10'h0}, {32'h0, 32'h22, 32'h11, 32'h0}, 8'h77);
    check("ack_lat_s1", bus1.rsp_valid, 1'b0);
    @(negedge clk);
    check("ack_valid", bus1.rsp_valid, 1'b1);
    check("ack_tag",   bus1.rsp_tag,   8'h77);
    check("ack_mask",  bus1.rsp_mask,  4'h6);
    check("ack_data",  bus1.rsp_data,  128'h0);
    send1(1'b0, 4'h1, 16'h0, {4{10'h007}}, '0, 8'h78);
    @(negedge clk);
    check("ack_rd_tag",  bus1.rsp_tag,  8'h78);
    check("ack_rd_data", bus1.rsp_data, {96'h0, 32'h22});
    send1(1'b1, 4'h0, 16'hFFFF, {4{10'h007}}, {4{32'hDEAD_BEEF}}, 8'h79);
    @(negedge clk);
    check("ack_m0_valid", bus1.rsp_valid, 1'b1);
    check("ack_m0_tag",   bus1.rsp_tag,   8'h79);
    check("ack_m0_mask",  bus1.rsp_mask,  4'h0);
    send1(1'b0, 4'h1, 16'h0, {4{10'h007}}, '0, 8'h7A);
    @(negedge clk);
    check("ack_m0_nochg", bus1.rsp_data, {96'h0, 32'h22});

    // full FIFO with rsp_ready pulses and a held request
    bus0.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_fill_ready", bus0.req_ready, 1'b1);
      drive_rd(8'(8'h30 + i), 0);
      exp_q.push_back(pk(8'(8'h30 + i), 4'h1, rd_exp(0)));
    end
    @(negedge clk);
    check("t5_full", bus0.req_ready, 1'b0);
    drive_rd(8'h34, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus0.rsp_ready = 1'b1;
      check("t5_hold_full", bus0.req_ready, 1'b0);
      @(negedge clk);
      bus0.rsp_ready = 1'b0;
      check("t5_reopen", bus0.req_ready, 1'b1);
      exp_q.push_back(pk(8'(8'h34 + k), 4'h1, rd_exp(0)));
      @(negedge clk);
      check("t5_refull", bus0.req_ready, 1'b0);
      drive_rd(8'(8'h35 + k), 0);
    end
    @(negedge clk);
    bus0.req_valid = 1'b0;
    bus0.rsp_ready = 1'b1;
    drain("t5_drain");

    // reset with queued responses; memory survives
    bus0.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send0(1'b0, 4'h1, 16'h0, ADDR_LIN, '0, 8'(8'h40 + i), '0, 1'b0);
    repeat (2) @(negedge clk);
    check("t6_queued", bus0.rsp_valid, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("t6_async_valid", bus0.rsp_valid, 1'b0);
    check("t6_async_tag",   bus0.rsp_tag,   8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("t6_ready", bus0.req_ready, 1'b1);
    check("t6_valid", bus0.rsp_valid, 1'b0);
    bus0.rsp_ready = 1'b1;
    send0(1'b0, 4'hF, 16'h0, ADDR_LIN, '0, 8'h50, DATA_LIN, 1'b1);
    send0(1'b0, 4'h1, 16'h0, {4{10'h007}}, '0, 8'h51, {96'h0, 32'h22}, 1'b1);
    send0(1'b0, 4'h1, 16'h0, {4{10'h003}}, '0, 8'h52, {96'h0, 32'hFFFF_12FF}, 1'b1);
    drain("t6_drain");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
